// File: rtl/map_pkg.sv
// Shared map definitions: default grid geometry, cell codes and clear-sequencer states.
package map_pkg;
   localparam int MAP_ROWS = 16;
   localparam int MAP_COLS = 16;
   localparam int MAP_BITS = 2;

   localparam logic [1:0] CELL_EMPTY  = 2'd0;
   localparam logic [1:0] CELL_WALL_A = 2'd1;
   localparam logic [1:0] CELL_WALL_B = 2'd2;
   localparam logic [1:0] CELL_WALL_C = 2'd3;

   typedef enum logic {SWEEP, IDLE} map_state_e;
endpackage

// File: rtl/map_ram_sweep.sv
// Clear sequencer: one cell per cycle in row-major order, busy for ROWS*COLS cycles.
// Starts after reset or on clear while idle; clear during a sweep is ignored.
module map_ram_sweep
   import map_pkg::*;
#(
   parameter int ROWS = MAP_ROWS,
   parameter int COLS = MAP_COLS
)(
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  clear,
   output logic                                  busy,
   output logic                                  sw_we,
   output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  sw_addr
);
   localparam int            AW   = $clog2(ROWS) + $clog2(COLS);
   localparam logic [AW-1:0] LAST = AW'(ROWS*COLS-1);

   map_state_e    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      case (state_q)
         SWEEP: begin
            // counter wraps back to 0 on the last cell, ready for the next sweep
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         IDLE: begin
            if (clear) begin
               state_d = SWEEP;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = SWEEP;
            cnt_d   = '0;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SWEEP;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign sw_we   = busy_q;
   assign sw_addr = cnt_q;
endmodule

// File: rtl/map_ram.sv
// Writable ROWS x COLS map store: registered 1-cycle reads on ports A and B, write port ready when not sweeping.
// Optional hard-wired border under MAP_RAM_BORDER_EN.
module map_ram
   import map_pkg::*;
#(
   parameter int ROWS       = MAP_ROWS,
   parameter int COLS       = MAP_COLS,
   parameter int BITS       = MAP_BITS,
   parameter int FILL_VAL   = int'(CELL_EMPTY),
   parameter int BORDER_VAL = int'(CELL_WALL_A)
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   output logic                    busy,
   input  logic                    a_req,
   input  logic [$clog2(ROWS)-1:0] a_row,
   input  logic [$clog2(COLS)-1:0] a_col,
   output logic [BITS-1:0]         a_val,
   output logic                    a_valid,
   input  logic [$clog2(ROWS)-1:0] b_row,
   input  logic [$clog2(COLS)-1:0] b_col,
   output logic [BITS-1:0]         b_val,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [$clog2(ROWS)-1:0] wr_row,
   input  logic [$clog2(COLS)-1:0] wr_col,
   input  logic [BITS-1:0]         wr_val
);
   localparam int RB    = $clog2(ROWS);
   localparam int CB    = $clog2(COLS);
   localparam int AW    = RB + CB;
   localparam int DEPTH = ROWS * COLS;
   localparam logic [BITS-1:0] FILL_C   = BITS'(FILL_VAL);
   localparam logic [BITS-1:0] BORDER_C = BITS'(BORDER_VAL);
`ifdef MAP_RAM_BORDER_EN
   localparam bit BORDER_EN = 1'b1;
`else
   localparam bit BORDER_EN = 1'b0;
`endif

   function automatic logic on_border(input logic [RB-1:0] r, input logic [CB-1:0] c);
      return BORDER_EN && (r == '0 || r == RB'(ROWS-1) || c == '0 || c == CB'(COLS-1));
   endfunction

   logic [BITS-1:0] mem [DEPTH];

   logic            sw_we;
   logic [AW-1:0]   sw_addr;
   logic            we;
   logic [AW-1:0]   w_addr;
   logic [BITS-1:0] w_dat;

   logic [BITS-1:0] a_val_q, a_val_d, b_val_q, b_val_d;
   logic            a_valid_q, a_valid_d;

   map_ram_sweep #(.ROWS(ROWS), .COLS(COLS)) u_sweep (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .busy    (busy),
      .sw_we   (sw_we),
      .sw_addr (sw_addr)
   );

   assign wr_ready = ~busy;

   // the sweep owns the write port while busy; border cells are never stored
   always_comb begin
      we     = sw_we;
      w_addr = sw_addr;
      w_dat  = FILL_C;
      if (!sw_we) begin
         we     = wr_valid;
         w_addr = {wr_row, wr_col};
         w_dat  = wr_val;
      end
      if (on_border(w_addr[AW-1:CB], w_addr[CB-1:0])) we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (we) mem[w_addr] <= w_dat;
   end

   always_comb begin
      a_valid_d = a_req & ~busy;
      a_val_d   = a_val_q;
      if (a_valid_d) a_val_d = on_border(a_row, a_col) ? BORDER_C : mem[{a_row, a_col}];
      b_val_d   = on_border(b_row, b_col) ? BORDER_C : mem[{b_row, b_col}];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_val_q   <= '0;
         a_valid_q <= 1'b0;
         b_val_q   <= '0;
      end else begin
         a_val_q   <= a_val_d;
         a_valid_q <= a_valid_d;
         b_val_q   <= b_val_d;
      end
   end

   assign a_val   = a_val_q;
   assign a_valid = a_valid_q;
   assign b_val   = b_val_q;
endmodule

// File: tb/tb_map_ram.sv
// Directed bench for map_ram with a reference map model and a queue of expected port-A reads.
module tb_map_ram;
   import map_pkg::*;

   localparam int ROWS = 16;
   localparam int COLS = 16;
   localparam int BITS = 2;
   localparam int RB   = 4;
   localparam int CB   = 4;
   localparam int N    = ROWS * COLS;
   localparam logic [BITS-1:0] FILL   = CELL_EMPTY;
   localparam logic [BITS-1:0] BORDER = CELL_WALL_A;

   logic            clk = 1'b0;
   logic            reset_n = 1'b1;
   logic            clear = 1'b0;
   logic            busy;
   logic            a_req = 1'b0;
   logic [RB-1:0]   a_row = '0;
   logic [CB-1:0]   a_col = '0;
   logic [BITS-1:0] a_val;
   logic            a_valid;
   logic [RB-1:0]   b_row = '0;
   logic [CB-1:0]   b_col = '0;
   logic [BITS-1:0] b_val;
   logic            wr_valid = 1'b0;
   logic            wr_ready;
   logic [RB-1:0]   wr_row = '0;
   logic [CB-1:0]   wr_col = '0;
   logic [BITS-1:0] wr_val = '0;

   always #5 clk = ~clk;

   map_ram #(.ROWS(ROWS), .COLS(COLS), .BITS(BITS), .FILL_VAL(0), .BORDER_VAL(1)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .busy(busy),
      .a_req(a_req), .a_row(a_row), .a_col(a_col), .a_val(a_val), .a_valid(a_valid),
      .b_row(b_row), .b_col(b_col), .b_val(b_val),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val)
   );

   logic [BITS-1:0] m_mem [N];
   bit              m_known [N];
   bit              m_busy;
   int              m_cnt;
   logic [BITS-1:0] aq [$];
   logic [BITS-1:0] last_a;
   int              n_checks = 0;
   int              n_pass = 0;
   int              n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

`ifdef MAP_RAM_BORDER_EN
   function automatic bit is_border(input int r, input int c);
      return r == 0 || r == ROWS-1 || c == 0 || c == COLS-1;
   endfunction
`endif

   function automatic bit m_kn(input int r, input int c);
`ifdef MAP_RAM_BORDER_EN
      if (is_border(r, c)) return 1'b1;
`endif
      return m_known[r*COLS+c];
   endfunction

   function automatic logic [BITS-1:0] m_rd(input int r, input int c);
`ifdef MAP_RAM_BORDER_EN
      if (is_border(r, c)) return BORDER;
`endif
      return m_mem[r*COLS+c];
   endfunction

   // one clock: predict from pre-edge model state, advance the model, then compare
   task automatic step();
      bit              exp_av;
      bit              b_kn;
      logic [BITS-1:0] exp_b;
      chk("wr_ready", wr_ready, !m_busy);
      exp_av = a_req && !m_busy;
      if (exp_av) aq.push_back(m_rd(int'(a_row), int'(a_col)));
      exp_b = m_rd(int'(b_row), int'(b_col));
      b_kn  = m_kn(int'(b_row), int'(b_col));
      if (m_busy) begin
         m_mem[m_cnt]   = FILL;
         m_known[m_cnt] = 1'b1;
         if (m_cnt == N-1) begin
            m_busy = 1'b0;
            m_cnt  = 0;
         end else m_cnt++;
      end else begin
         if (wr_valid) begin
            m_mem[int'(wr_row)*COLS+int'(wr_col)]   = wr_val;
            m_known[int'(wr_row)*COLS+int'(wr_col)] = 1'b1;
         end
         if (clear) begin
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("busy", busy, m_busy);
      chk("a_valid", a_valid, exp_av);
      if (exp_av) begin
         last_a = aq.pop_front();
         chk("a_val", a_val, last_a);
      end else chk("a_hold", a_val, last_a);
      if (b_kn) chk("b_val", b_val, exp_b);
   endtask

   task automatic do_reset(input int cycles);
      #2 reset_n = 1'b0;
      #1;
      m_busy     = 1'b1;
      m_cnt      = 0;
      m_known[0] = 1'b0;
      aq.delete();
      last_a = '0;
      chk("rst_busy", busy, 1);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_a_val", a_val, 0);
      chk("rst_b_val", b_val, 0);
      chk("rst_wr_ready", wr_ready, 0);
      repeat (cycles) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic run_sweep(input string tag, input int clr_at);
      int n = 0;
      while (busy === 1'b1 && n < 1000) begin
         clear = (n == clr_at);
         step();
         n++;
      end
      clear = 1'b0;
      chk(tag, n, N);
   endtask

   task automatic set_a(input int r, input int c);
      a_row = RB'(r);
      a_col = CB'(c);
   endtask

   task automatic set_wr(input int r, input int c, input logic [BITS-1:0] v);
      wr_row = RB'(r);
      wr_col = CB'(c);
      wr_val = v;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         m_known[i] = 1'b0;
         m_mem[i]   = '0;
      end
      m_busy = 1'b1;
      m_cnt  = 0;
      last_a = '0;

      do_reset(3);
      run_sweep("sweep_len", -1);
      chk("ready_after_sweep", wr_ready, 1);

      // every cell through port A, port B walking the map backwards
      for (int i = 0; i < N; i++) begin
         set_a(i / COLS, i % COLS);
         b_row = RB'((N-1-i) / COLS);
         b_col = CB'((N-1-i) % COLS);
         a_req = 1'b1;
         step();
      end
      a_req = 1'b0;
      step();

      set_wr(3, 5, CELL_WALL_B);
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      set_a(3, 5);
      a_req = 1'b1;
      step();
      chk("rd_3_5", a_val, 2);
      a_req = 1'b0;
      step();
      step();
      chk("hold_3_5", a_val, 2);

      // same-edge write and reads see old data, next read sees new
      set_wr(7, 7, CELL_WALL_C);
      wr_valid = 1'b1;
      set_a(7, 7);
      b_row = 4'd7;
      b_col = 4'd7;
      a_req = 1'b1;
      step();
      wr_valid = 1'b0;
      chk("rdw_a_old", a_val, 0);
      chk("rdw_b_old", b_val, 0);
      step();
      chk("rdw_a_new", a_val, 3);
      chk("rdw_b_new", b_val, 3);

      set_wr(2, 2, CELL_WALL_A);
      wr_valid = 1'b1;
      a_req = 1'b0;
      step();
      wr_valid = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      set_a(2, 2);
      a_req = 1'b1;
      set_wr(9, 9, CELL_WALL_C);
      wr_valid = 1'b1;
      run_sweep("clear_len", 100);
      step();
      wr_valid = 1'b0;
      chk("cleared_2_2", a_val, 0);
      set_a(9, 9);
      step();
      chk("held_write_9_9", a_val, 3);

`ifdef MAP_RAM_BORDER_EN
      set_wr(0, 4, CELL_WALL_C);
      wr_valid = 1'b1;
      a_req = 1'b0;
      chk("border_wr_ready", wr_ready, 1);
      step();
      wr_valid = 1'b0;
      set_a(0, 4);
      b_row = 4'd0;
      b_col = 4'd4;
      a_req = 1'b1;
      step();
      chk("border_0_4", a_val, 1);
      chk("border_b_0_4", b_val, 1);
      set_a(15, 15);
      step();
      chk("border_15_15", a_val, 1);
      set_a(1, 1);
      step();
      chk("inner_1_1", a_val, 0);
`endif

      set_wr(4, 4, CELL_WALL_B);
      wr_valid = 1'b1;
      a_req = 1'b0;
      step();
      wr_valid = 1'b0;
      set_a(4, 4);
      a_req = 1'b1;
      step();
      a_req = 1'b0;
      chk("pre_rst_4_4", a_val, 2);
      clear = 1'b1;
      step();
      clear = 1'b0;
      repeat (100) step();
      do_reset(2);
      run_sweep("rst_sweep_len", -1);
      set_a(4, 4);
      a_req = 1'b1;
      step();
      a_req = 1'b0;
      chk("post_rst_4_4", a_val, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
